// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory boot loader.
// State encoding and stream framing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WR,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Byte-to-word packer: collects 4 bytes LSB first.
// last flags that the next accepted byte completes the word.
module byte_word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        full,
  output logic        last
);

  logic [1:0] idx;

  assign last = (idx == 2'(WORD_BYTES - 1));

  // Place each byte at its lane; index wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx  <= '0;
      word <= '0;
      full <= 1'b0;
    end else if (en) begin
      word[{idx, 3'b000} +: 8] <= data;
      idx  <= idx + 2'd1;
      full <= last;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> imem words, checksum gate.
// Holds the core in reset until a clean image is loaded.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] words_loaded
);

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic [31:0] n_words;
  logic [7:0]  csum;
  logic [31:0] hdr_word;
  logic [31:0] wl_next;
  logic [31:0] pk_word;
  logic        pk_full;
  logic        pk_last;
  logic        pk_en;
  logic        pk_clear;

  assign accept   = in_valid & in_ready;
  assign pk_en    = accept & ((state == HDR) | (state == DATA));
  assign pk_clear = (state == WR);
  assign hdr_word = {in_data, pk_word[23:0]};
  assign wl_next  = words_loaded + 32'd1;

  byte_word_packer u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (pk_clear),
    .en    (pk_en),
    .data  (in_data),
    .word  (pk_word),
    .full  (pk_full),
    .last  (pk_last)
  );

  assign imem_we    = (state == WR) & pk_full;
  assign imem_addr  = imem_we
                    ? BASE_ADDR + {words_loaded[29:0], 2'b00}
                    : '0;
  assign imem_wdata = imem_we ? pk_word : '0;

  // Next-state decode for the load sequence.
  always_comb begin
    state_nx = state;
    unique case (state)
      HDR: begin
        if (accept && pk_last) begin
          if (hdr_word > 32'(MEM_WORDS))
            state_nx = ERR;
          else if (hdr_word == '0)
            state_nx = CHK;
          else
            state_nx = DATA;
        end
      end
      DATA: begin
        if (accept && pk_last)
          state_nx = WR;
      end
      WR: begin
        state_nx = (wl_next == n_words) ? CHK : DATA;
      end
      CHK: begin
        if (accept)
          state_nx = (in_data == csum) ? DONE : ERR;
      end
      DONE: state_nx = DONE;
      ERR:  state_nx = ERR;
      default: state_nx = HDR;
    endcase
  end

  // State, counters, checksum and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HDR;
      n_words      <= '0;
      csum         <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b1;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == HDR && accept && pk_last)
        n_words <= hdr_word;
      if (state == DATA && accept)
        csum <= csum ^ in_data;
      if (state == WR)
        words_loaded <= wl_next;
      in_ready   <= (state_nx == HDR) | (state_nx == DATA)
                  | (state_nx == CHK);
      cpu_reset  <= (state_nx != DONE);
      load_done  <= (state_nx == DONE);
      load_error <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table vectors, corner
// sequences and random streams against a stream model.
module tb_imem_boot_loader;

  localparam logic [31:0] MEMW  = 32'd256;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        r0, we0, cr0, dn0, er0;
  logic [31:0] addr0, wd0, wl0;
  logic        r1, we1, cr1, dn1, er1;
  logic [31:0] addr1, wd1, wl1;

  imem_boot_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .cpu_reset(cr0), .load_done(dn0), .load_error(er0),
    .words_loaded(wl0)
  );

  imem_boot_loader #(.MEM_WORDS(256), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(r1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .cpu_reset(cr1), .load_done(dn1), .load_error(er1),
    .words_loaded(wl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream[$];
  logic [31:0] exp_w[$];
  logic [63:0] cap0[$];
  logic [63:0] cap1[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_acc;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Record every write; the loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (!reset) begin
      if (we0) begin
        cap0.push_back({addr0, wd0});
        total++;
        if (r0 !== 1'b0) begin
          bad++;
          $display("FAIL ready_in_wr: got %b want 0", r0);
        end
      end
      if (we1)
        cap1.push_back({addr1, wd1});
    end
  end

  // Reference: interpret the byte stream from the framing rules.
  task automatic model_run();
    logic [31:0] n;
    logic [7:0]  cs;
    int          p;
    exp_w.delete();
    exp_done = 0;
    exp_err  = 0;
    if (stream.size() < 4) begin
      exp_acc = stream.size();
      return;
    end
    n = {stream[3], stream[2], stream[1], stream[0]};
    if (n > MEMW) begin
      exp_err = 1;
      exp_acc = 4;
      return;
    end
    cs = 8'h00;
    p  = 4;
    for (int i = 0; i < int'(n); i++) begin
      if (p + 4 > stream.size()) begin
        exp_acc = stream.size();
        return;
      end
      exp_w.push_back({stream[p+3], stream[p+2], stream[p+1], stream[p]});
      cs ^= stream[p] ^ stream[p+1] ^ stream[p+2] ^ stream[p+3];
      p += 4;
    end
    if (p >= stream.size()) begin
      exp_acc = stream.size();
      return;
    end
    exp_acc = p + 1;
    if (stream[p] == cs) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      stream.push_back(w[8*k +: 8]);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    while (r0 !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: got ready=%b want 1", r0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_ctl0", {r0, we0, cr0, dn0, er0}, 5'b10100);
    check("rst_ctl1", {r1, we1, cr1, dn1, er1}, 5'b10100);
    check("rst_addr", {addr0, addr1}, 64'h0);
    check("rst_wdata", {wd0, wd1}, 64'h0);
    check("rst_words", {wl0, wl1}, 64'h0);
    reset = 1'b0;
    cap0.delete();
    cap1.delete();
  endtask

  // mode 0: back to back, 1: one idle cycle between bytes, 2: random gaps
  task automatic run_stream(input int mode);
    int gap;
    model_run();
    for (int i = 0; i < exp_acc; i++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      send_byte(stream[i], gap);
    end
    check("status0", {dn0, er0, cr0}, {exp_done, exp_err, !exp_done});
    check("status1", {dn1, er1, cr1}, {exp_done, exp_err, !exp_done});
    if ((exp_done || exp_err) && exp_acc < stream.size()) begin
      in_valid = 1'b1;
      in_data  = stream[exp_acc];
      repeat (4) @(negedge clk);
      check("ready_term", {r0, r1}, 2'b00);
      in_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("sticky", {dn0, er0, cr0}, {exp_done, exp_err, !exp_done});
    check("words0", wl0, exp_w.size());
    check("words1", wl1, exp_w.size());
    check("nwr0", cap0.size(), exp_w.size());
    check("nwr1", cap1.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < cap0.size()
                    && i < cap1.size(); i++) begin
      check("wr0", cap0[i], {BASE0 + 32'(4 * i), exp_w[i]});
      check("wr1", cap1[i], {BASE1 + 32'(4 * i), exp_w[i]});
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    bit          csum_fixed;
    logic [7:0]  csum;
    bit          toggle;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0]  cs;
    logic [31:0] n;
    logic [31:0] w;

    vecs[0] = '{32'd1,   32'h0050_0013, 1, 8'h43, 0, 1, 0, 1};
    vecs[1] = '{32'd3,   32'hA1B2_C3D4, 0, 8'h00, 1, 1, 0, 3};
    vecs[2] = '{32'd1,   32'h0050_0013, 1, 8'h42, 0, 0, 1, 1};
    vecs[3] = '{32'd257, 32'h0,         0, 8'h00, 0, 0, 1, 0};
    vecs[4] = '{32'd0,   32'h0,         1, 8'h00, 0, 1, 0, 0};
    vecs[5] = '{32'd256, 32'h0302_0100, 0, 8'h00, 0, 1, 0, 256};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0,   0, 8'h00, 0, 0, 1, 0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    foreach (vecs[v]) begin
      do_reset();
      stream.delete();
      push_word(vecs[v].n);
      cs = 8'h00;
      if (vecs[v].n <= MEMW) begin
        for (int i = 0; i < int'(vecs[v].n); i++) begin
          w = vecs[v].w0 + 32'(i) * 32'h0404_0404;
          push_word(w);
          cs ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        stream.push_back(vecs[v].csum_fixed ? vecs[v].csum : cs);
      end
      stream.push_back(8'hEE);
      stream.push_back(8'hEE);
      run_stream(vecs[v].toggle ? 1 : 0);
      check("t_done", dn0, vecs[v].exp_done);
      check("t_err", er0, vecs[v].exp_err);
      check("t_nw", cap0.size(), vecs[v].exp_nw);
      if (vecs[v].exp_nw == 256 && cap0.size() == 256)
        check("t_last_addr", cap0[255][63:32], 32'h0000_03FC);
    end

    // Minimal image: exact write contents.
    do_reset();
    stream.delete();
    push_word(32'd1);
    push_word(32'h0050_0013);
    stream.push_back(8'h43);
    run_stream(0);
    if (cap0.size() == 1)
      check("min_write", cap0[0], {32'h0, 32'h0050_0013});
    check("min_words", wl0, 32'd1);

    // Reset after two of four words, then a clean reload.
    do_reset();
    stream.delete();
    push_word(32'd4);
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC);
    push_word(32'hDDEE_FF00);
    stream.push_back(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66
                   ^ 8'h77 ^ 8'h88 ^ 8'h99 ^ 8'hAA ^ 8'hBB ^ 8'hCC
                   ^ 8'hDD ^ 8'hEE ^ 8'hFF ^ 8'h00);
    for (int i = 0; i < 12; i++)
      send_byte(stream[i], 0);
    @(negedge clk);
    check("mid_words", wl0, 32'd2);
    check("mid_nwr", cap0.size(), 2);
    check("mid_cpu_rst", cr0, 1'b1);
    do_reset();
    run_stream(0);
    check("reload_done", dn0, 1'b1);

    // Random images, good or corrupted checksum, random valid gaps.
    for (int t = 0; t < 30; t++) begin
      do_reset();
      stream.delete();
      if ($urandom_range(0, 9) == 0)
        n = 32'd257 + 32'($urandom_range(0, 70000));
      else
        n = 32'($urandom_range(0, 6));
      push_word(n);
      cs = 8'h00;
      if (n <= MEMW) begin
        for (int i = 0; i < int'(n); i++) begin
          w = $urandom;
          push_word(w);
          cs ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        if ($urandom_range(0, 2) == 0)
          cs ^= 8'($urandom_range(1, 255));
        stream.push_back(cs);
      end
      stream.push_back(8'($urandom));
      run_stream(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
